// File: rtl/fetch_controller.sv
// fetch_controller: PC-driven instruction fetch into a 2-entry buffer toward decode, with redirect and error trap.
// Optional fetch counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_controller #(
  parameter int          MEM_BYTES = 16,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_address,
  input  logic [31:0] Instruction,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2;
  localparam logic [63:0] MEM_LIM = 64'(MEM_BYTES);
  logic [1:0]  state, count;
  logic [63:0] pc, pc0, pc1, pc_inc, pc_next;
  logic [31:0] in0, in1;
  logic        pop, push, redir, bad, good, wr0;
  assign Inst_address = pc;
  assign inst_valid   = count != 2'd0 && state != ERR;
  assign inst_out     = in0;
  assign inst_pc      = pc0;
  assign pop          = inst_valid & inst_ready;
  // redirects are ignored once trapped in ERR
  assign redir        = redirect_valid && state != ERR;
  assign bad          = redir && (redirect_pc[1:0] != 2'd0 || redirect_pc >= MEM_LIM);
  assign good         = redir && !bad;
  assign push         = state == RUN && fetch_en && !redir && (count != 2'd2 || pop);
  assign pc_inc       = pc + 64'd4;
  assign pc_next      = pc_inc == MEM_LIM ? 64'd0 : pc_inc;
  assign wr0          = count == 2'd0 || (count == 2'd1 && pop);
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc           <= RESET_PC;
      count        <= 2'd0;
      state        <= IDLE;
      misalign_err <= 1'b0;
    end else begin
      if (good) pc <= redirect_pc;
      else if (push) pc <= pc_next;
      if (bad) begin
        state        <= ERR;
        misalign_err <= 1'b1;
      end else if (state == IDLE && fetch_en) state <= RUN;
      else if (state == RUN && !fetch_en) state <= IDLE;
      count <= redir ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    end
  end
  // pop shifts entry 1 forward; a push then lands in the first free slot
  always_ff @(posedge clk) begin
    if (pop) begin
      pc0 <= pc1;
      in0 <= in1;
    end
    if (push && wr0) begin
      pc0 <= pc;
      in0 <= Instruction;
    end else if (push) begin
      pc1 <= pc;
      in1 <= Instruction;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (!reset) cnt <= 32'd0;
    else if (push) cnt <= cnt + 32'd1;
  end
  assign fetch_count = cnt;
`else
  assign fetch_count = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of sequencing, stall, redirect, error trap and reset.
module tb_fetch_controller;
  logic        clk = 0, reset = 0, fetch_en = 0, redirect_valid = 0, inst_ready = 0;
  logic [63:0] redirect_pc = '0, inst_address, inst_pc;
  logic [31:0] instruction, inst_out, fetch_count;
  logic        inst_valid, misalign_err;
  int          n_cmp = 0, n_err = 0;
  fetch_controller #(.MEM_BYTES(16), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .Inst_address(inst_address), .Instruction(instruction),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction
  assign instruction = mem(inst_address);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  logic [63:0] seq [6] = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd0, 64'd4};
  logic [31:0] cnt6;
  initial begin
`ifdef FETCH_PERF_CNT_EN
    cnt6 = 32'd6;
`else
    cnt6 = 32'd0;
`endif
    tick();
    check("rst_valid", inst_valid, 0);
    check("rst_addr", inst_address, 0);
    check("rst_err", misalign_err, 0);
    check("rst_cnt", fetch_count, 0);
    reset = 1; fetch_en = 1; inst_ready = 1;
    tick();
    check("first_run_valid", inst_valid, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("seq_valid", inst_valid, 1);
      check($sformatf("seq_pc%0d", i), inst_pc, seq[i]);
      check("seq_instr", inst_out, mem(seq[i]));
    end
    check("cnt_after6", fetch_count, cnt6);
    reset = 0; redirect_valid = 1; redirect_pc = 64'd6;
    tick();
    check("mid_rst_valid", inst_valid, 0);
    check("mid_rst_addr", inst_address, 0);
    check("mid_rst_cnt", fetch_count, 0);
    check("mid_rst_err", misalign_err, 0);
    reset = 1; redirect_valid = 0; inst_ready = 0;
    tick(2);
    check("stall_first", inst_pc, 0);
    tick(5);
    check("stall_addr", inst_address, 8);
    check("stall_head", inst_pc, 0);
    check("stall_valid", inst_valid, 1);
    inst_ready = 1;
    tick();
    check("stall_next", inst_pc, 4);
    check("stall_addr2", inst_address, 12);
    redirect_valid = 1; redirect_pc = 64'd12;
    tick();
    check("redir_flush", inst_valid, 0);
    check("redir_addr", inst_address, 12);
    redirect_valid = 0;
    tick();
    check("redir_valid", inst_valid, 1);
    check("redir_pc", inst_pc, 12);
    check("redir_instr", inst_out, mem(64'd12));
    check("wrap_addr", inst_address, 0);
    redirect_valid = 1; redirect_pc = 64'd6;
    tick();
    check("mis_err", misalign_err, 1);
    check("mis_valid", inst_valid, 0);
    check("mis_addr", inst_address, 0);
    redirect_pc = 64'd4;
    tick();
    redirect_valid = 0;
    tick(2);
    check("err_hold_addr", inst_address, 0);
    check("err_hold_valid", inst_valid, 0);
    check("err_hold_flag", misalign_err, 1);
    reset = 0; fetch_en = 0;
    tick();
    check("err_rst_flag", misalign_err, 0);
    reset = 1; redirect_valid = 1; redirect_pc = 64'd8;
    tick();
    check("idle_redir_addr", inst_address, 8);
    check("idle_redir_valid", inst_valid, 0);
    redirect_valid = 0; fetch_en = 1;
    tick(2);
    check("idle_redir_pc", inst_pc, 8);
    check("idle_redir_next", inst_address, 12);
    redirect_valid = 1; redirect_pc = 64'd16;
    tick();
    check("oor_err", misalign_err, 1);
    check("oor_valid", inst_valid, 0);
    check("oor_addr", inst_address, 12);
    redirect_valid = 0;
    tick(2);
    check("oor_hold_addr", inst_address, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 16, meaning instruction memory size in bytes (multiple of 4).
REQ-002 SHALL have parameter RESET_PC, default 64'd0, meaning PC loaded on reset.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-005 SHALL have port Inst_address  output  64  fetch address driven to instruction memory.
REQ-006 SHALL have port Instruction  input  32  memory read data, combinationally valid for Inst_address in the same cycle.
REQ-007 SHALL have port fetch_en  input  1  fetch permitted when 1.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  64  redirect target.
REQ-010 SHALL have port inst_valid  output  1  buffer head valid toward decode.
REQ-011 SHALL have port inst_ready  input  1  decode accepts head.
REQ-012 SHALL have port inst_out  output  32  head instruction.
REQ-013 SHALL have port inst_pc  output  64  head instruction's PC.
REQ-014 SHALL have port misalign_err  output  1  sticky bad-redirect flag.
REQ-015 SHALL have port fetch_count  output  32  instructions fetched (see Configuration).

Function
REQ-016 SHALL hold a 64-bit PC register; Inst_address SHALL equal PC combinationally.
REQ-017 SHALL hold a 2-entry FIFO of {pc[63:0], instr[31:0]}; inst_out/inst_pc SHALL show the head entry; inst_valid = (count != 0) and state != ERR.
REQ-018 SHALL implement states IDLE, RUN, ERR; IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; any->ERR on bad redirect; ERR exits only via reset.
REQ-019 Pop SHALL occur on inst_valid & inst_ready at the clock edge.
REQ-020 In RUN with no redirect, push SHALL occur when count<2, or count==2 with a pop in the same cycle; push writes {PC, Instruction}, then PC <= PC+4.
REQ-021 PC+4 == MEM_BYTES SHALL wrap PC to 0.
REQ-022 Latency: push at edge ending cycle n -> inst_valid=1 in cycle n+1 if FIFO was empty.
REQ-023 redirect_valid=1 with redirect_pc[1:0]==0 and redirect_pc<MEM_BYTES SHALL, at that edge: flush FIFO (count<=0, no push), PC<=redirect_pc; a simultaneous pop is a completed transfer; valid in any state except ERR.
REQ-024 Redirect with redirect_pc[1:0]!=0 or redirect_pc>=MEM_BYTES SHALL flush FIFO, leave PC unchanged, set misalign_err=1, enter ERR.
REQ-025 Redirect SHALL take priority over fetch in the same cycle; redirect target first appears on inst_valid two cycles after redirect cycle (if RUN).
REQ-026 IDLE SHALL retain FIFO contents and PC; pops continue in IDLE.
REQ-027 ERR SHALL perform no push and no PC update; inst_valid=0.

Reset
REQ-028 reset=0 at an edge SHALL set PC=RESET_PC, count=0, state=IDLE, misalign_err=0, fetch_count=0, overriding redirect and fetch in the same cycle.
REQ-029 After reset: inst_valid=0, Inst_address=RESET_PC; reset mid-operation discards buffered instructions.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: fetch_count SHALL increment by 1 on every push, wrapping 0xFFFFFFFF->0, cleared only by reset.
REQ-031 Macro FETCH_PERF_CNT_EN undefined: fetch_count SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-032 Reset, fetch_en=1, inst_ready=1, MEM_BYTES=16 -> inst_pc sequence 0,4,8,12,0,4; first inst_valid one cycle after first RUN cycle.
REQ-033 inst_ready=0 for 5 cycles in RUN -> count stalls at 2, Inst_address holds 8, heads 0 then 4 delivered in order after ready=1.
REQ-034 Redirect to 12 while FIFO holds PCs 4,8 and pop occurs same cycle -> PC 4 accepted, PC 8 dropped, next inst_pc=12 two cycles later.
REQ-035 Redirect to 6 (misaligned) or 16 (out of range) -> misalign_err=1 next cycle, inst_valid=0, Inst_address unchanged until reset.
REQ-036 reset=0 for one edge mid-stream -> next cycle inst_valid=0, Inst_address=0, fetch_count=0; with FETCH_PERF_CNT_EN, 6 pushes -> fetch_count=6, without -> 0.
